cog_ctrn: RTL

Multi-channel, width-parametrised cog counter block: CHANNELS independent counter units sharing one cog clock, each with NCO, duty-cycle, pin-accumulate and logic modes, plus a new period-capture mode. Sits inside the cog beside the instruction pipeline and is written by CTRx/FRQx/PHSx writes. It drives the cog's pin-output OR-tree and returns PHS/capture values to the ALU read mux. The analog PLL path is not carried over; all logic runs on clk_cog.

---
 rtl/cog_ctrn_if.sv | 39 +++
 rtl/cog_ctrn.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cog_ctrn_if.sv
// cog_ctrn_if: write/pin bus between the cog core and the counter block.
//   sel       channel addressed by setctr/setfrq/setphs/clrflg
//   setctr, setfrq, setphs, clrflg  write/clear strobes for channel sel
//   data      32-bit write data
//   pin_in    pin inputs
//   phs       per channel {carry, accumulator}, channel 0 in the LSBs
//   cap       per channel captured period
//   cap_flag  per channel capture-done flag
//   pin_out   OR of all channel pin outputs
// master: cog core side (drives strobes); slave: counter block side.
interface cog_ctrn_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned PHS_W    = 32,
  parameter int unsigned PINS     = 32
);
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [SEL_W-1:0]              sel;
  logic                          setctr;
  logic                          setfrq;
  logic                          setphs;
  logic                          clrflg;
  logic [31:0]                   data;
  logic [PINS-1:0]               pin_in;
  logic [CHANNELS*(PHS_W+1)-1:0] phs;
  logic [CHANNELS*PHS_W-1:0]     cap;
  logic [CHANNELS-1:0]           cap_flag;
  logic [PINS-1:0]               pin_out;

  modport master (
    output sel, setctr, setfrq, setphs, clrflg, data, pin_in,
    input  phs, cap, cap_flag, pin_out
  );

  modport slave (
    input  sel, setctr, setfrq, setphs, clrflg, data, pin_in,
    output phs, cap, cap_flag, pin_out
  );
endinterface

// File: rtl/cog_ctrn.sv
// cog_ctrn: CHANNELS independent cog counter units on clk_cog.
// Each unit offers NCO, duty-cycle, pin-accumulate, logic and (optionally) period-capture modes.
//   clk_cog  cog clock, all state on the rising edge
//   ena      asynchronous active-low reset (cog enable)
//   bus      cog_ctrn_if.slave: write strobes, data, pin_in in; phs, cap, cap_flag, pin_out out
// Optional feature macro: COG_CTR_CAPTURE_EN
//   defined     -> capture mode (00001), cap registers, cap_flag and clrflg are present
//   not defined -> mode 00001 behaves as off, cap/cap_flag tied to 0, clrflg ignored
// Per-channel ctr fields kept: mode = ctr[30:26], pin B = ctr[13:9], pin A = ctr[4:0].
module cog_ctrn #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned PHS_W    = 32,
  parameter int unsigned PINS     = 32
) (
  input  logic      clk_cog,
  input  logic      ena,
  cog_ctrn_if.slave bus
);

  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PIN_W = (PINS > 1) ? $clog2(PINS) : 1;

  // Mode codes for ctr[30:26]; only the upper bits are decoded directly.
  localparam logic [4:0] MODE_OFF     = 5'b00000;
  localparam logic [4:0] MODE_CAPTURE = 5'b00001;

  logic [4:0]       mode_q  [CHANNELS];
  logic [PIN_W-1:0] pin_a_q [CHANNELS];
  logic [PIN_W-1:0] pin_b_q [CHANNELS];
  logic [PHS_W-1:0] frq_q   [CHANNELS];
  logic [PHS_W:0]   phs_q   [CHANNELS];
  logic [1:0]       dly_q   [CHANNELS];
  logic [1:0]       dly_d   [CHANNELS];

  logic [CHANNELS-1:0] wr;
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] outa;
  logic [CHANNELS-1:0] outb;
  logic [CHANNELS-1:0] dly_en;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] nco_bit;
  logic [PINS-1:0]     pin_vec;

  // Mode decode: trig / outb / outa plus delay-line enable per channel.
  always_comb begin
    wr      = '0;
    trig    = '0;
    outa    = '0;
    outb    = '0;
    dly_en  = '0;
    hit     = '0;
    nco_bit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr[i] = (bus.sel == SEL_W'(i));
      // Pin B only feeds dly[1] in logic modes; edge modes shift dly[0] into dly[1].
      dly_d[i] = {mode_q[i][4] ? bus.pin_in[pin_b_q[i]] : dly_q[i][0], bus.pin_in[pin_a_q[i]]};

      if (mode_q[i][4]) begin
        // Logic mode: ctr[29:26] is a truth table indexed by {B, A}.
        dly_en[i] = 1'b1;
        trig[i]   = mode_q[i][{1'b0, dly_q[i]}];
      end else if (mode_q[i][3]) begin
        dly_en[i] = 1'b1;
        case (mode_q[i][2:1])
          2'b00:   trig[i] = dly_q[i][0];
          2'b01:   trig[i] = (dly_q[i] == 2'b01);
          2'b10:   trig[i] = ~dly_q[i][0];
          default: trig[i] = (dly_q[i] == 2'b10);
        endcase
        // Odd codes feed the inverted sampled pin A back out on pin B.
        outb[i] = mode_q[i][0] & ~dly_q[i][0];
      end else if (mode_q[i][2]) begin
        // NCO uses the accumulator MSB, duty uses the carry of the last add.
        trig[i]    = 1'b1;
        nco_bit[i] = mode_q[i][1] ? phs_q[i][PHS_W] : phs_q[i][PHS_W-1];
        outa[i]    = nco_bit[i];
        outb[i]    = mode_q[i][0] & ~nco_bit[i];
`ifdef COG_CTR_CAPTURE_EN
      end else if (mode_q[i] == MODE_CAPTURE) begin
        dly_en[i] = 1'b1;
        trig[i]   = 1'b1;
        hit[i]    = (dly_q[i] == 2'b01);
`endif
      end else begin
        // Off and reserved codes leave every output at its default.
        trig[i] = (mode_q[i] != MODE_OFF) & 1'b0;
      end
    end
  end

  // Counter state; ena low clears everything immediately.
  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= '0;
        pin_a_q[i] <= '0;
        pin_b_q[i] <= '0;
        frq_q[i]   <= '0;
        phs_q[i]   <= '0;
        dly_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (dly_en[i]) begin
          dly_q[i] <= dly_d[i];
        end
        if (wr[i] && bus.setctr) begin
          mode_q[i]  <= bus.data[30:26];
          pin_b_q[i] <= bus.data[9 +: PIN_W];
          pin_a_q[i] <= bus.data[PIN_W-1:0];
        end
        if (wr[i] && bus.setfrq) begin
          frq_q[i] <= bus.data[PHS_W-1:0];
        end
        // A direct phs write wins over capture reload and accumulation.
        if (wr[i] && bus.setphs) begin
          phs_q[i] <= {1'b0, bus.data[PHS_W-1:0]};
        end else if (hit[i]) begin
          // Reload with frq so the capture clock itself counts toward the next period.
          phs_q[i] <= {1'b0, frq_q[i]};
        end else if (trig[i]) begin
          phs_q[i] <= {1'b0, phs_q[i][PHS_W-1:0]} + {1'b0, frq_q[i]};
        end
      end
    end
  end

`ifdef COG_CTR_CAPTURE_EN
  logic [PHS_W-1:0]    cap_q [CHANNELS];
  logic [CHANNELS-1:0] cap_flag_q;

  always_ff @(posedge clk_cog or negedge ena) begin
    if (!ena) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cap_q[i] <= '0;
      end
      cap_flag_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (hit[i]) begin
          // A capture always records and flags, even alongside setphs/clrflg.
          cap_q[i]      <= phs_q[i][PHS_W-1:0];
          cap_flag_q[i] <= 1'b1;
        end else if (wr[i] && (bus.clrflg || bus.setphs)) begin
          cap_flag_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.cap = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.cap[i*PHS_W +: PHS_W] = cap_q[i];
    end
  end

  assign bus.cap_flag = cap_flag_q;
`else
  assign bus.cap      = '0;
  assign bus.cap_flag = '0;
`endif

  always_comb begin
    bus.phs = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.phs[i*(PHS_W+1) +: (PHS_W+1)] = phs_q[i];
    end
  end

  // Pin output OR-tree over all channels.
  always_comb begin
    pin_vec = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (outa[i]) begin
        pin_vec[pin_a_q[i]] = 1'b1;
      end
      if (outb[i]) begin
        pin_vec[pin_b_q[i]] = 1'b1;
      end
    end
  end

  assign bus.pin_out = pin_vec;

endmodule
